// File: rtl/stim_sequencer_if.sv
// DUT-facing bus of the stimulus sequencer: reset, stimulus vector,
// response vector and vector-apply strobe/index.
interface stim_sequencer_if #(
    parameter int IN_W  = 140,
    parameter int OUT_W = 159
);
    logic             dut_rst_n;
    logic [IN_W-1:0]  dut_in;
    logic [OUT_W-1:0] dut_out;
    logic             vec_valid;
    logic [31:0]      vec_idx;

    modport master (
        output dut_rst_n, dut_in, vec_valid, vec_idx,
        input  dut_out
    );

    modport slave (
        input  dut_rst_n, dut_in, vec_valid, vec_idx,
        output dut_out
    );
endinterface

// File: rtl/stim_sequencer.sv
// Reset/stimulus sequencer: resets the DUT, drives LCG vectors and
// folds every DUT response into a 32-bit rotating signature.
module stim_sequencer #(
    parameter int          IN_W       = 140,
    parameter int          OUT_W      = 159,
    parameter logic [31:0] SEED       = 32'd1791895503,
    parameter int          RST_CYCLES = 2,
    parameter logic [31:0] LCG_MUL    = 32'h41C64E6D,
    parameter logic [31:0] LCG_INC    = 32'h3039
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 seed_load,
    input  logic [31:0]          seed_in,
    input  logic [31:0]          num_vec,
    stim_sequencer_if.master     bus,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          signature
);
    localparam int NW = (IN_W + 31) / 32;
    localparam int NO = (OUT_W + 31) / 32;
    localparam int WW = (NW > 1) ? $clog2(NW) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RESET = 3'd1;
    localparam logic [2:0] S_FILL  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        r_state;
    logic [31:0]       r_lcg;
    logic [31:0]       r_num;
    logic [31:0]       r_rcnt;
    logic [WW-1:0]     r_w;
    logic [32*NW-1:0]  r_shadow;
    logic [IN_W-1:0]   r_dut_in;
    logic [31:0]       r_idx;
    logic [31:0]       r_sig;
    logic              r_dut_rst_n;
    logic              r_apply;
    logic              r_vv;
    logic              r_first;
    logic              r_busy;
    logic              r_done;

    logic [31:0]       w_lcg_nx;
    logic [32*NW-1:0]  w_vec;
    logic [32*NO-1:0]  w_pad;
    logic [31:0]       w_fold;
    logic [31:0]       w_sig_nx;
    logic [31:0]       w_idx_nx;
    logic              w_last;

    assign w_lcg_nx = r_lcg * LCG_MUL + LCG_INC;
    assign w_last   = (r_w == WW'(NW - 1));
    assign w_idx_nx = r_first ? 32'd0 : r_idx + 32'd1;
    assign w_sig_nx = {r_sig[30:0], r_sig[31]} ^ w_fold;

    always_comb begin
        w_vec = r_shadow;
        w_vec[int'(r_w)*32 +: 32] = w_lcg_nx;
    end

    // Response folded as XOR of zero-padded 32-bit chunks
    always_comb begin
        w_pad = '0;
        w_pad[OUT_W-1:0] = bus.dut_out;
        w_fold = '0;
        for (int k = 0; k < NO; k++)
            w_fold = w_fold ^ w_pad[k*32 +: 32];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_lcg       <= SEED;
            r_num       <= '0;
            r_rcnt      <= '0;
            r_w         <= '0;
            r_shadow    <= '0;
            r_dut_in    <= '0;
            r_idx       <= '0;
            r_sig       <= '0;
            r_dut_rst_n <= 1'b0;
            r_apply     <= 1'b0;
            r_vv        <= 1'b0;
            r_first     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_vv    <= r_apply;
            r_apply <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (seed_load)
                        r_lcg <= seed_in;
                    if (start) begin
                        r_num       <= num_vec;
                        r_sig       <= '0;
                        r_idx       <= '0;
                        r_done      <= 1'b0;
                        r_busy      <= 1'b1;
                        r_dut_rst_n <= 1'b0;
                        r_rcnt      <= '0;
                        r_first     <= 1'b1;
                        r_state     <= S_RESET;
                    end
                end
                S_RESET: begin
                    if (r_rcnt == 32'(RST_CYCLES - 1)) begin
                        r_dut_rst_n <= 1'b1;
                        r_w         <= '0;
                        r_state     <= S_FILL;
                    end else begin
                        r_rcnt <= r_rcnt + 32'd1;
                    end
                end
                S_FILL: begin
                    r_lcg    <= w_lcg_nx;
                    r_shadow <= w_vec;
                    if (w_last) begin
                        r_w      <= '0;
                        r_dut_in <= w_vec[IN_W-1:0];
                        r_apply  <= 1'b1;
                        r_idx    <= w_idx_nx;
                        r_first  <= 1'b0;
                        // Response to the previous vector is still on dut_out
                        if (!r_first)
                            r_sig <= w_sig_nx;
                        if (w_idx_nx == r_num)
                            r_state <= S_DRAIN;
                    end else begin
                        r_w <= r_w + WW'(1);
                    end
                end
                S_DRAIN: begin
                    r_sig   <= w_sig_nx;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.dut_rst_n = r_dut_rst_n;
    assign bus.dut_in    = r_dut_in;
    assign bus.vec_valid = r_vv;
    assign bus.vec_idx   = r_idx;
    assign busy          = r_busy;
    assign done          = r_done;
    assign signature     = r_sig;
endmodule

// File: doc/stim_sequencer.md
Name: stim_sequencer

Overview:
Self-contained stimulus/reset sequencer for the flat-vector `top` datapath (IN_W-bit `in_flat`, OUT_W-bit `out_flat`). On `start` it holds the DUT in reset, then applies a deterministic run of LCG-generated input vectors and folds every DUT output into a 32-bit signature. It lets synthesizable harnesses and emulation builds replay the same stimulus sequence as the simulation bench, with no testbench-side generator.

Parameters:
IN_W, 140, width of DUT input vector
OUT_W, 159, width of DUT output vector
SEED, 1791895503, LCG state after reset and after a `start` with no preceding `seed_load`
RST_CYCLES, 2, cycles `dut_rst_n` is held low per run (must be >= 1)
LCG_MUL, 32'h41C64E6D, LCG multiplier
LCG_INC, 32'h3039, LCG increment

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle run request; honoured only in IDLE or DONE
seed_load  in  1  load `seed_in` into LCG state; honoured only in IDLE or DONE
seed_in  in  32  seed value
num_vec  in  32  vectors applied after the initial vector; sampled on accepted `start`
dut_rst_n  out  1  reset to DUT, active low
dut_in  out  IN_W  vector driven to DUT
dut_out  in  OUT_W  DUT output vector
vec_valid  out  1  one-cycle pulse, high the cycle after `dut_in` changes
vec_idx  out  32  index of the vector on `dut_in` (0 = initial vector)
busy  out  1  high in RESET, FILL and DRAIN
done  out  1  level; set at run end, cleared by next accepted `start`
signature  out  32  running output signature

Behaviour:
- Reset (async assert, sync deassert): state=IDLE; dut_rst_n=0, dut_in=0, vec_valid=0, vec_idx=0, busy=0, done=0, signature=0, lcg=SEED, word counter w=0. Reset mid-run aborts with no residual state.
- NW = ceil(IN_W/32). One LCG step per word: lcg <= lcg*LCG_MUL + LCG_INC (mod 2^32). Word k of a vector takes the k-th new state. The last word is truncated to its low IN_W-32*(NW-1) bits.
- seed_load and start in the same cycle: the load wins for lcg, and the run starts with the new seed.
- IDLE/DONE: on `start`, latch num_vec, clear signature, vec_idx and done, set busy, and go to RESET. `start` is ignored in every other state.
- RESET: dut_rst_n=0 for exactly RST_CYCLES cycles, then go to FILL with w=0. dut_rst_n=1 from FILL entry until the next run's RESET.
- FILL: each cycle, one LCG step, with the word written to a shadow register at w*32.
  - At w=NW-1: dut_in <= {new word, shadow lower words} at that edge; vec_valid pulses next cycle; w <= 0.
  - Each application after the first increments vec_idx.
  - Cadence: one vector every NW cycles. First vec_valid appears RST_CYCLES+NW+1 cycles after the `start` edge.
- Signature update: sig <= {sig[30:0],sig[31]} ^ F(dut_out). F = XOR of the 32-bit chunks of dut_out zero-padded to 32*ceil(OUT_W/32). Sampled at the edge that applies vectors 1..num_vec (capturing the previous vector's response), and once in DRAIN.
- After vector num_vec is applied (num_vec+1 vectors total), go to DRAIN. num_vec=0 applies only vector 0.
- DRAIN: one cycle of signature sampling, then DONE with busy=0 and done=1. dut_in, vec_idx and lcg hold their values; the next run continues the LCG sequence unless seed_load is used.
- vec_idx wraps modulo 2^32; no overflow flag.

Test Plan:
- Reset values: assert rst_n mid-FILL -> immediately dut_rst_n=0, dut_in=0, busy=0, done=0, signature=0; after release, state is IDLE.
- IN_W=40, seed_load 0, start, num_vec=0 -> dut_rst_n low 2 cycles; dut_in=40'h7E00003039 (words 0x00003039, 0xD3DC167E), vec_idx=0, one vec_valid pulse; then done=1.
- Defaults, seed_load 1, num_vec=3 -> word0 of vector 0 = 0x41C67EA6; exactly 4 vec_valid pulses spaced 5 cycles; vec_idx 0..3; done=1, busy=0 after DRAIN.
- Signature: dut_out tied constant 0 -> signature 0; dut_out=OUT_W'(1), num_vec=2 -> 3 updates: 1, 3, 7 -> signature 32'h7.
- start while busy ignored -> vec_idx sequence unaffected; start in DONE -> done clears next cycle, signature=0, LCG continues from last state.
- seed_load and start in the same cycle with seed_in=0 -> run equals the seed-0 reference sequence.
